data_ram_responder: RTL
=======================

DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning data RAM depth in bytes; address index = low 8 bits.
REQ-002 SHALL have parameter DUMP_BASE, default 8'h00, meaning first RAM address streamed out after the program finishes.
REQ-003 SHALL have parameter DUMP_LEN, default 9'd16, meaning number of bytes streamed out (0..256).
REQ-004 MAIN_CLOCK  in  1  the only clock; all logic updates on its rising edge.
REQ-005 RESET  in  1  reset; synchronous and active-high.
REQ-006 CPU_CLOCK  in  1  processor tick, a level signal generated from MAIN_CLOCK; the block detects its rising edge internally.
REQ-007 CPU_ADDRESS  in  16  processor data address.
REQ-008 CPU_DATA  in  8  processor write data.
REQ-009 CPU_WRITE_EN  in  1  processor write request.
REQ-010 PROCESS_FINISHED  in  1  processor halted.
REQ-011 DATA_FROM_RAM  out  8  read data returned to the processor.
REQ-012 HOST_VALID / HOST_DATA / HOST_LAST  in  1/8/1  load stream into RAM.
REQ-013 HOST_READY  out  1  load stream accept.
REQ-014 OUT_VALID / OUT_DATA  out  1/8  dump stream; OUT_READY  in  1  sink accept.
REQ-015 CPU_START  out  1  high while the processor may run.
REQ-016 DUMP_DONE  out  1  dump complete.
REQ-017 ADDR_ERROR  out  1  sticky flag; processor used an address >= DEPTH.

Function
REQ-018 SHALL run FSM states LOAD, RUN, DUMP, DONE.
REQ-019 LOAD: HOST_READY=1; each HOST_VALID&HOST_READY cycle writes HOST_DATA to load_ptr, then load_ptr increments.
REQ-020 LOAD exit: a handshake with HOST_LAST=1, or the write to address DEPTH-1, SHALL move to RUN on the next edge.
REQ-021 RUN: CPU_START=1 and HOST_READY=0.
REQ-022 cpu_tick SHALL be CPU_CLOCK high AND its registered previous value low.
REQ-023 In RUN, cpu_tick with CPU_WRITE_EN=1 SHALL write CPU_DATA to RAM[CPU_ADDRESS[7:0]].
REQ-024 DATA_FROM_RAM SHALL be registered every MAIN_CLOCK cycle from RAM[CPU_ADDRESS[7:0]]; latency 1 cycle.
REQ-025 On a same-cycle write to the same address, DATA_FROM_RAM SHALL return the new data (write-first).
REQ-026 CPU writes outside RUN SHALL be ignored.
REQ-027 CPU_ADDRESS[15:8] != 0 SHALL set ADDR_ERROR on cpu_tick in RUN; such writes are dropped; ADDR_ERROR clears only on RESET.
REQ-028 RUN exit: PROCESS_FINISHED=1 SHALL move to DUMP next edge and drop CPU_START; if DUMP_LEN=0, SHALL move to DONE instead.
REQ-029 DUMP: reads RAM sequentially from DUMP_BASE; address wraps modulo 256.
REQ-030 First OUT_VALID SHALL assert on the 2nd cycle in DUMP (1-cycle RAM read latency).
REQ-031 OUT_VALID/OUT_DATA SHALL hold stable while OUT_READY=0.
REQ-032 Each OUT_VALID&OUT_READY cycle SHALL advance to the next byte with no bubble when OUT_READY is held high.
REQ-033 After DUMP_LEN handshakes the FSM SHALL enter DONE: OUT_VALID=0, DUMP_DONE=1; DONE is terminal until RESET.
REQ-034 HOST_VALID in any state other than LOAD SHALL be ignored.

Reset
REQ-035 RESET SHALL set: state LOAD, load_ptr 0, dump counter 0, DATA_FROM_RAM 8'h00, OUT_VALID 0, OUT_DATA 8'h00, CPU_START 0, DUMP_DONE 0, ADDR_ERROR 0, previous CPU_CLOCK 0.
REQ-036 RAM contents SHALL NOT be cleared by RESET; reset mid-RUN or mid-DUMP SHALL abort to LOAD on the next edge.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding (2-bit), DEPTH, and address width 8.
REQ-038 One sub-module, ram_256x8, SHALL provide the single-port synchronous write-first RAM; the rest is FSM, counters and mux in data_ram_responder.

Verification
REQ-039 Load 4 bytes 11,22,33,44 with LAST on the 4th -> RAM[0..3] holds them; RUN on next edge; CPU_START=1.
REQ-040 RUN, CPU_ADDRESS=0x0005, CPU_DATA=0xA5, WE=1, one CPU_CLOCK rise -> exactly one write; DATA_FROM_RAM=0xA5 one cycle later; CPU_CLOCK held high 3 cycles gives no extra write.
REQ-041 RUN, CPU_ADDRESS=0x0105 with WE -> ADDR_ERROR=1; RAM[5] unchanged.
REQ-042 DUMP_BASE=0xFE, DUMP_LEN=4, OUT_READY toggling -> bytes of addresses FE,FF,00,01 in order, held while stalled; DUMP_DONE=1 after the 4th.
REQ-043 256-byte load with no LAST -> auto RUN after address 0xFF.
REQ-044 RESET in DUMP after 2 bytes -> LOAD, OUT_VALID=0, RAM preserved; DUMP_LEN=0 goes RUN -> DONE directly.

Source files
------------

// File: rtl/data_ram_responder_pkg.sv
// Shared definitions for the data RAM responder.
// Holds the 2-bit FSM state encoding, the RAM geometry and a small
// address-range helper used by the processor write path.
package data_ram_responder_pkg;

    localparam int RAM_DEPTH = 256;
    localparam int ADDR_W    = 8;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // A processor address is usable only when its upper byte is zero.
    function automatic logic addr_in_range(input logic [15:0] addr);
        return (addr[15:8] == 8'h00);
    endfunction

endpackage

// File: rtl/data_ram_responder_ram_256x8.sv
// ram_256x8: single-port synchronous 256x8 RAM, write-first.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset of the read register only
//           (memory contents are never cleared)
//   addr  - byte address
//   we    - write enable
//   wdata - write data
//   rdata - registered read data; returns wdata on a write cycle
module ram_256x8
    import data_ram_responder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [7:0]        wdata,
    output logic [7:0]        rdata
);

    logic [7:0] mem_r [RAM_DEPTH];
    logic [7:0] rdata_r;

    // Memory array write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read register: new data wins on a same-address write.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 8'h00;
        end else if (we) begin
            rdata_r <= wdata;
        end else begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_ram_responder.sv
// data_ram_responder: data RAM for a small processor with a host load
// stream before the program runs and a dump stream after it halts.
// Ports:
//   MAIN_CLOCK, RESET              - clock and synchronous active-high reset
//   CPU_CLOCK                      - processor tick level (rising edge detected here)
//   CPU_ADDRESS/DATA/WRITE_EN      - processor data port
//   PROCESS_FINISHED               - processor halted
//   DATA_FROM_RAM                  - registered read data to the processor
//   HOST_VALID/DATA/LAST, HOST_READY - load stream
//   OUT_VALID/OUT_DATA, OUT_READY  - dump stream
//   CPU_START, DUMP_DONE, ADDR_ERROR - status
// The single RAM port is shared: LOAD writes use load_ptr, DUMP reads use
// the dump pointer, otherwise the port follows CPU_ADDRESS. DATA_FROM_RAM
// and OUT_DATA are both the RAM read register.
module data_ram_responder
    import data_ram_responder_pkg::*;
#(
    parameter int         DEPTH     = RAM_DEPTH,
    parameter logic [7:0] DUMP_BASE = 8'h00,
    parameter logic [8:0] DUMP_LEN  = 9'd16
) (
    input  logic        MAIN_CLOCK,
    input  logic        RESET,
    input  logic        CPU_CLOCK,
    input  logic [15:0] CPU_ADDRESS,
    input  logic [7:0]  CPU_DATA,
    input  logic        CPU_WRITE_EN,
    input  logic        PROCESS_FINISHED,
    output logic [7:0]  DATA_FROM_RAM,
    input  logic        HOST_VALID,
    input  logic [7:0]  HOST_DATA,
    input  logic        HOST_LAST,
    output logic        HOST_READY,
    output logic        OUT_VALID,
    output logic [7:0]  OUT_DATA,
    input  logic        OUT_READY,
    output logic        CPU_START,
    output logic        DUMP_DONE,
    output logic        ADDR_ERROR
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_r;
    logic [ADDR_W-1:0] load_ptr_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [8:0]        dump_cnt_r;
    logic              cpu_clock_prev_r;
    logic              host_ready_r;
    logic              cpu_start_r;
    logic              out_valid_r;
    logic              dump_done_r;
    logic              addr_error_r;

    logic              cpu_tick_s;
    logic              host_fire_s;
    logic              out_fire_s;
    logic              cpu_we_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic              ram_we_s;
    logic [7:0]        ram_wdata_s;
    logic [7:0]        ram_rdata_s;

    assign cpu_tick_s  = CPU_CLOCK & ~cpu_clock_prev_r;
    assign host_fire_s = (state_r == ST_LOAD) & HOST_VALID;
    assign out_fire_s  = (state_r == ST_DUMP) & out_valid_r & OUT_READY;
    assign cpu_we_s    = (state_r == ST_RUN) & cpu_tick_s & CPU_WRITE_EN
                         & addr_in_range(CPU_ADDRESS);

    // RAM port steering. On a dump handshake the next byte is fetched so
    // it appears with no bubble; while stalled the same address is re-read
    // so OUT_DATA holds.
    always_comb begin
        ram_addr_s  = CPU_ADDRESS[ADDR_W-1:0];
        ram_we_s    = 1'b0;
        ram_wdata_s = CPU_DATA;
        case (state_r)
            ST_LOAD: begin
                if (host_fire_s) begin
                    ram_addr_s  = load_ptr_r;
                    ram_we_s    = ~RESET;
                    ram_wdata_s = HOST_DATA;
                end else begin
                    ram_we_s = 1'b0;
                end
            end
            ST_RUN: begin
                ram_we_s = cpu_we_s & ~RESET;
            end
            ST_DUMP: begin
                ram_addr_s = out_fire_s ? (rd_addr_r + 8'd1) : rd_addr_r;
            end
            ST_DONE: begin
                ram_we_s = 1'b0;
            end
            default: begin
                ram_we_s = 1'b0;
            end
        endcase
    end

    ram_256x8 u_ram (
        .clk   (MAIN_CLOCK),
        .rst   (RESET),
        .addr  (ram_addr_s),
        .we    (ram_we_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // Main FSM with its counters and registered status outputs.
    always_ff @(posedge MAIN_CLOCK) begin
        if (RESET) begin
            state_r          <= ST_LOAD;
            load_ptr_r       <= 8'h00;
            rd_addr_r        <= 8'h00;
            dump_cnt_r       <= 9'd0;
            cpu_clock_prev_r <= 1'b0;
            host_ready_r     <= 1'b1;
            cpu_start_r      <= 1'b0;
            out_valid_r      <= 1'b0;
            dump_done_r      <= 1'b0;
            addr_error_r     <= 1'b0;
        end else begin
            cpu_clock_prev_r <= CPU_CLOCK;
            case (state_r)
                ST_LOAD: begin
                    if (host_fire_s) begin
                        load_ptr_r <= load_ptr_r + 8'd1;
                        if (HOST_LAST || (load_ptr_r == LAST_ADDR)) begin
                            state_r      <= ST_RUN;
                            host_ready_r <= 1'b0;
                            cpu_start_r  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (cpu_tick_s && !addr_in_range(CPU_ADDRESS)) begin
                        addr_error_r <= 1'b1;
                    end
                    if (PROCESS_FINISHED) begin
                        cpu_start_r <= 1'b0;
                        rd_addr_r   <= DUMP_BASE;
                        dump_cnt_r  <= 9'd0;
                        if (DUMP_LEN == 9'd0) begin
                            state_r     <= ST_DONE;
                            dump_done_r <= 1'b1;
                        end else begin
                            state_r <= ST_DUMP;
                        end
                    end
                end
                ST_DUMP: begin
                    // First DUMP cycle only primes the RAM read.
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (OUT_READY) begin
                        rd_addr_r  <= rd_addr_r + 8'd1;
                        dump_cnt_r <= dump_cnt_r + 9'd1;
                        if (dump_cnt_r == (DUMP_LEN - 9'd1)) begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b0;
                            dump_done_r <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_DONE;
                end
                default: begin
                    state_r <= ST_LOAD;
                end
            endcase
        end
    end

    assign DATA_FROM_RAM = ram_rdata_s;
    assign OUT_DATA      = ram_rdata_s;
    assign HOST_READY    = host_ready_r;
    assign OUT_VALID     = out_valid_r;
    assign CPU_START     = cpu_start_r;
    assign DUMP_DONE     = dump_done_r;
    assign ADDR_ERROR    = addr_error_r;

endmodule
